// File: rtl/enemy_sched.sv
// Enemy kill arbiter and score keeper: round-robin one-hot kill grant, per-enemy alive/dead state, score accumulation.
// Latency: hit_ack, alive, score_out and player_collision all update one clock after the sampled request; all_dead is combinational from alive.
// Backpressure: none; requests are levels that the block samples every cycle, and a request from a dead enemy is ignored.
//
// Ports:
//   clk              single rising-edge clock
//   rst              synchronous active-high reset: all enemies alive, score cleared, pointer at 0
//   frame_tick       one-cycle pulse per video frame; advances respawn counters
//   hit_req[N]       level, enemy i overlaps the hero attack
//   coll_req[N]      level, enemy i overlaps the hero
//   hit_ack[N]       registered one-hot kill grant (or zero)
//   alive[N]         per-enemy alive flags (draw enables)
//   score_out[24]    accumulated score, saturating at 24'hFFFFFF
//   player_collision registered: hero touches a live enemy
//   all_dead         high when no enemy is alive
//
// Build option: define ENEMY_RESPAWN_EN to give each enemy a respawn counter
// that brings it back after RESPAWN_FRAMES frame ticks. Without it, a killed
// enemy stays dead until rst and frame_tick is ignored.

module enemy_sched #(
    parameter int          N_ENEMY        = 5,
    parameter logic [23:0] SCORE_STEP     = 24'd100,
    parameter int          RESPAWN_FRAMES = 120
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [N_ENEMY-1:0] hit_req,
    input  logic [N_ENEMY-1:0] coll_req,
    output logic [N_ENEMY-1:0] hit_ack,
    output logic [N_ENEMY-1:0] alive,
    output logic [23:0]        score_out,
    output logic               player_collision,
    output logic               all_dead
);

    localparam int PTR_W = (N_ENEMY > 2) ? $clog2(N_ENEMY) : 1;

    typedef enum logic {
        ST_DEAD  = 1'b0,
        ST_ALIVE = 1'b1
    } enemy_state_t;

    enemy_state_t       state_q [N_ENEMY];
    enemy_state_t       state_d [N_ENEMY];

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;

    logic [N_ENEMY-1:0] eligible;
    logic [N_ENEMY-1:0] grant;
    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     scan_sum;
    logic [PTR_W-1:0]   scan_idx;

    logic [N_ENEMY-1:0] hit_ack_q;
    logic [23:0]        score_q;
    logic [23:0]        score_d;
    logic [24:0]        score_sum;
    logic               coll_q;

`ifdef ENEMY_RESPAWN_EN
    logic [7:0]         cnt_q [N_ENEMY];
    logic [7:0]         cnt_d [N_ENEMY];
`else
    // frame_tick has no consumer when respawn is compiled out.
    logic               unused_frame_tick;
    assign unused_frame_tick = frame_tick;
`endif

    // ------------------------------------------------------------------
    // Alive flags straight from the registered per-enemy state.
    // ------------------------------------------------------------------
    always_comb begin
        alive = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            alive[i] = (state_q[i] == ST_ALIVE);
        end
    end

    // Only live enemies compete; registered alive means an enemy that
    // respawns this cycle cannot be granted until the next one.
    assign eligible = hit_req & alive;

    // ------------------------------------------------------------------
    // Round-robin scan: first eligible index at or after ptr_q, wrapping.
    // The scan offset is added in PTR_W+1 bits so the wrap is a single
    // conditional subtract rather than a modulo.
    // ------------------------------------------------------------------
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_ENEMY; k++) begin
            scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(N_ENEMY)) begin
                scan_sum = scan_sum - (PTR_W+1)'(N_ENEMY);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!grant_vld && eligible[scan_idx]) begin
                grant_vld       = 1'b1;
                grant_idx       = scan_idx;
                grant[scan_idx] = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner; it holds when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            if (grant_idx == PTR_W'(N_ENEMY - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + PTR_W'(1);
            end
        end
    end

    // Score adds in 25 bits; a carry out means the sum passed 24'hFFFFFF.
    always_comb begin
        score_sum = {1'b0, score_q} + {1'b0, SCORE_STEP};
        score_d   = score_q;
        if (grant_vld) begin
            score_d = score_sum[24] ? 24'hFFFFFF : score_sum[23:0];
        end
    end

    // ------------------------------------------------------------------
    // Per-enemy next state. A grant only ever targets a live enemy and the
    // respawn path only ever touches a dead one, so the two are exclusive.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_ENEMY; i++) begin
            state_d[i] = state_q[i];
`ifdef ENEMY_RESPAWN_EN
            cnt_d[i]   = cnt_q[i];
`endif
            if (grant[i]) begin
                state_d[i] = ST_DEAD;
`ifdef ENEMY_RESPAWN_EN
                cnt_d[i]   = 8'(RESPAWN_FRAMES);
`endif
            end
`ifdef ENEMY_RESPAWN_EN
            else if ((state_q[i] == ST_DEAD) && frame_tick) begin
                // A tick that finds the counter at 1 is the last dead frame.
                if (cnt_q[i] <= 8'd1) begin
                    state_d[i] = ST_ALIVE;
                    cnt_d[i]   = 8'd0;
                end else begin
                    cnt_d[i]   = cnt_q[i] - 8'd1;
                end
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // State registers. Reset wins over every same-cycle event, including
    // an in-flight respawn.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ENEMY; i++) begin
                state_q[i] <= ST_ALIVE;
`ifdef ENEMY_RESPAWN_EN
                cnt_q[i]   <= 8'd0;
`endif
            end
            ptr_q     <= '0;
            hit_ack_q <= '0;
            score_q   <= '0;
            coll_q    <= 1'b0;
        end else begin
            for (int i = 0; i < N_ENEMY; i++) begin
                state_q[i] <= state_d[i];
`ifdef ENEMY_RESPAWN_EN
                cnt_q[i]   <= cnt_d[i];
`endif
            end
            ptr_q     <= ptr_d;
            hit_ack_q <= grant;
            score_q   <= score_d;
            // Uses alive before this edge's kill, so a kill and a
            // collision on the same enemy are both reported.
            coll_q    <= |(coll_req & alive);
        end
    end

    assign hit_ack          = hit_ack_q;
    assign score_out        = score_q;
    assign player_collision = coll_q;
    assign all_dead         = (alive == '0);

endmodule

// File: tb/tb_enemy_sched.sv
module tb_enemy_sched;

    localparam int RF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ft  = 1'b0;
    logic [7:0] hit = 8'h00;
    logic [7:0] coll = 8'h00;

    // Instance 0: 5 enemies, default score step.
    logic [4:0]  ack0, alive0;
    logic [23:0] score0;
    logic        pc0, ad0;
    // Instance 1: 8 enemies, large step so saturation is reachable quickly.
    logic [7:0]  ack1, alive1;
    logic [23:0] score1;
    logic        pc1, ad1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    enemy_sched #(.N_ENEMY(5), .SCORE_STEP(24'd100), .RESPAWN_FRAMES(RF)) dut (
        .clk(clk), .rst(rst), .frame_tick(ft),
        .hit_req(hit[4:0]), .coll_req(coll[4:0]),
        .hit_ack(ack0), .alive(alive0), .score_out(score0),
        .player_collision(pc0), .all_dead(ad0)
    );

    enemy_sched #(.N_ENEMY(8), .SCORE_STEP(24'h333330), .RESPAWN_FRAMES(RF)) dut8 (
        .clk(clk), .rst(rst), .frame_tick(ft),
        .hit_req(hit), .coll_req(coll),
        .hit_ack(ack1), .alive(alive1), .score_out(score1),
        .player_collision(pc1), .all_dead(ad1)
    );

    // ---------------- reference model (per instance u) ----------------
    bit         m_alive [2][8];
    int         m_cnt   [2][8];
    int         m_ptr   [2];
    longint     m_score [2];
    logic [7:0] m_ack   [2];
    bit         m_coll  [2];

    function automatic int n_of(input int u);
        return (u == 0) ? 5 : 8;
    endfunction

    function automatic longint step_of(input int u);
        return (u == 0) ? 64'd100 : 64'h333330;
    endfunction

    function automatic logic [7:0] m_alive_vec(input int u);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < n_of(u); i++) v[i] = m_alive[u][i];
        return v;
    endfunction

    task automatic m_update(input int u, input logic r, input logic [7:0] h,
                            input logic [7:0] c, input logic f);
        int n;
        int g;
        n = n_of(u);
        if (r) begin
            for (int i = 0; i < 8; i++) begin
                m_alive[u][i] = 1'b1;
                m_cnt[u][i]   = 0;
            end
            m_ptr[u]   = 0;
            m_score[u] = 0;
            m_ack[u]   = 8'h00;
            m_coll[u]  = 1'b0;
        end else begin
            m_coll[u] = 1'b0;
            for (int i = 0; i < n; i++)
                if (c[i] && m_alive[u][i]) m_coll[u] = 1'b1;
            g = -1;
            for (int k = 0; k < n; k++) begin
                int i;
                i = (m_ptr[u] + k) % n;
                if (g < 0 && h[i] && m_alive[u][i]) g = i;
            end
            m_ack[u] = 8'h00;
`ifdef ENEMY_RESPAWN_EN
            for (int i = 0; i < n; i++) begin
                if (!m_alive[u][i] && f) begin
                    if (m_cnt[u][i] == 1) begin
                        m_alive[u][i] = 1'b1;
                        m_cnt[u][i]   = 0;
                    end else begin
                        m_cnt[u][i] = m_cnt[u][i] - 1;
                    end
                end
            end
`else
            if (f && 1'b0) m_ptr[u] = m_ptr[u];
`endif
            if (g >= 0) begin
                m_ack[u][g]   = 1'b1;
                m_alive[u][g] = 1'b0;
                m_cnt[u][g]   = RF;
                m_score[u]    = m_score[u] + step_of(u);
                if (m_score[u] > 64'hFFFFFF) m_score[u] = 64'hFFFFFF;
                m_ptr[u]      = (g + 1) % n;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [7:0] a0, a1;
        a0 = m_alive_vec(0);
        a1 = m_alive_vec(1);
        chk({tag, "/ack0"},   32'(ack0),   32'(m_ack[0][4:0]));
        chk({tag, "/alive0"}, 32'(alive0), 32'(a0[4:0]));
        chk({tag, "/score0"}, 32'(score0), 32'(m_score[0]));
        chk({tag, "/coll0"},  32'(pc0),    32'(m_coll[0]));
        chk({tag, "/dead0"},  32'(ad0),    32'(a0[4:0] == 5'd0));
        chk({tag, "/ack1"},   32'(ack1),   32'(m_ack[1]));
        chk({tag, "/alive1"}, 32'(alive1), 32'(a1));
        chk({tag, "/score1"}, 32'(score1), 32'(m_score[1]));
        chk({tag, "/coll1"},  32'(pc1),    32'(m_coll[1]));
        chk({tag, "/dead1"},  32'(ad1),    32'(a1 == 8'd0));
    endtask

    task automatic step(input logic r, input logic [7:0] h, input logic [7:0] c,
                        input logic f, input string tag);
        @(negedge clk);
        rst  = r;
        hit  = h;
        coll = c;
        ft   = f;
        @(posedge clk);
        m_update(0, r, h, c, f);
        m_update(1, r, h, c, f);
        #1;
        compare_all(tag);
    endtask

    initial begin
        // Reset state
        step(1'b1, 8'h00, 8'h00, 1'b0, "rst");
        step(1'b1, 8'h00, 8'h00, 1'b0, "rst");
        chk("rst_alive",  32'(alive0), 32'h1F);
        chk("rst_ack",    32'(ack0),   32'h0);
        chk("rst_score",  32'(score0), 32'h0);
        chk("rst_coll",   32'(pc0),    32'h0);
        chk("rst_dead",   32'(ad0),    32'h0);

        // Single kill of enemy 2
        step(1'b0, 8'h04, 8'h00, 1'b0, "kill2");
        chk("kill2_ack",   32'(ack0),   32'h04);
        chk("kill2_alive", 32'(alive0), 32'h1B);
        chk("kill2_score", 32'(score0), 32'd100);
        step(1'b0, 8'h00, 8'h00, 1'b0, "kill2_idle");
        chk("kill2_pulse", 32'(ack0), 32'h0);

        // Round robin with a held two-enemy request
        step(1'b1, 8'h00, 8'h00, 1'b0, "rst");
        step(1'b0, 8'h11, 8'h00, 1'b0, "rr1");
        chk("rr1_ack", 32'(ack0), 32'h01);
        step(1'b0, 8'h11, 8'h00, 1'b0, "rr2");
        chk("rr2_ack", 32'(ack0), 32'h10);
        step(1'b0, 8'h11, 8'h00, 1'b0, "rr3");
        chk("rr3_ack",   32'(ack0),   32'h00);
        chk("rr3_score", 32'(score0), 32'd200);

        // Collision against a dead enemy, respawn behaviour
        step(1'b1, 8'h00, 8'h00, 1'b0, "rst");
        step(1'b0, 8'h02, 8'h00, 1'b0, "kill1");
        step(1'b0, 8'h00, 8'h02, 1'b0, "coll_dead");
        chk("coll_dead", 32'(pc0), 32'h0);
`ifdef ENEMY_RESPAWN_EN
        step(1'b0, 8'h00, 8'h00, 1'b1, "tick1");
        chk("tick1_alive1", 32'(alive0[1]), 32'h0);
        step(1'b0, 8'h00, 8'h00, 1'b1, "tick2");
        chk("tick2_alive1", 32'(alive0[1]), 32'h0);
        step(1'b0, 8'h02, 8'h00, 1'b1, "tick3");
        chk("tick3_alive1", 32'(alive0[1]), 32'h1);
        chk("tick3_noack",  32'(ack0),      32'h0);
        step(1'b0, 8'h02, 8'h00, 1'b0, "rekill");
        chk("rekill_ack", 32'(ack0), 32'h02);
        step(1'b0, 8'h00, 8'h00, 1'b1, "midresp");
        step(1'b1, 8'h00, 8'h00, 1'b1, "rst_abort");
        chk("rst_abort_alive", 32'(alive0), 32'h1F);
`endif
        step(1'b1, 8'h00, 8'h00, 1'b0, "rst");
        step(1'b0, 8'h00, 8'h02, 1'b0, "coll_live");
        chk("coll_live", 32'(pc0), 32'h1);
        step(1'b0, 8'h02, 8'h02, 1'b0, "kill_coll");
        chk("kill_coll_pc",    32'(pc0),    32'h1);
        chk("kill_coll_ack",   32'(ack0),   32'h02);
        chk("kill_coll_score", 32'(score0), 32'd100);

        // Saturation on the 8-enemy instance, all_dead on the 5-enemy one
        step(1'b1, 8'h00, 8'h00, 1'b0, "rst");
        for (int k = 0; k < 5; k++) step(1'b0, 8'h3F, 8'h00, 1'b0, "sat");
        chk("sat_pre",  32'(score1), 32'hFFFFF0);
        chk("all_dead", 32'(ad0),    32'h1);
        step(1'b0, 8'h3F, 8'h00, 1'b0, "sat");
        chk("sat_max", 32'(score1), 32'hFFFFFF);
`ifndef ENEMY_RESPAWN_EN
        for (int k = 0; k < 500; k++) step(1'b0, 8'hFF, 8'h00, 1'b1, "no_resp");
        chk("no_resp_alive", 32'(alive0), 32'h0);
        step(1'b1, 8'h00, 8'h00, 1'b0, "rst");
        chk("no_resp_rst", 32'(alive0), 32'h1F);
`endif

        // Randomized traffic against the model
        step(1'b1, 8'h00, 8'h00, 1'b0, "rst");
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 31) == 0, 8'($urandom & $urandom), 8'($urandom),
                 $urandom_range(0, 3) == 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
